// File: rtl/cpu_test_monitor.sv
// cpu_test_monitor: snoops the cpu retire stream and the dmem write port,
// latches the program outcome (PASS/FAIL/TIMEOUT) and counts cycles,
// retired instructions and (optionally) misaligned stores.
// Optional feature macro: CPU_TEST_MONITOR_MISALIGN_EN
//   defined   -> RUN-state stores with dmem_addr[1:0] != 0 set misalign_err
//   undefined -> misalign logic removed, misalign_err tied to 0
module cpu_test_monitor #(
    parameter logic [31:0] STATUS_ADDR  = 32'h0000_0000,
    parameter logic [31:0] STATUS_PASS  = 32'hC0DE_CAFE,
    parameter logic [31:0] END_SENTINEL = 32'h0000_006F,
    parameter int          MAX_CYCLES   = 20,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    input  logic [31:0]          instr,
    input  logic [31:0]          pc,
    input  logic                 mem_write,
    input  logic [31:0]          dmem_addr,
    input  logic [31:0]          dmem_wdata,
    output logic [1:0]           state,
    output logic                 pass,
    output logic                 fail,
    output logic [31:0]          halt_pc,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 misalign_err
);

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_DONE    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(MAX_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic [31:0]          halt_pc_q, halt_pc_d;
    logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;

    logic in_run;
    logic status_store;
    logic sentinel;

    assign in_run       = (state_q == ST_RUN);
    assign status_store = mem_write && (dmem_addr == STATUS_ADDR);
    assign sentinel     = instr_valid && (instr == END_SENTINEL);

    // Next-state: counters, outcome flags and RUN -> DONE/TIMEOUT transitions.
    always_comb begin
        // NOTE: every *_d defaults to its *_q first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        halt_pc_d     = halt_pc_q;
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;

        if (in_run) begin
            if (cycle_count_q != CNT_MAX) begin
                cycle_count_d = cycle_count_q + 1'b1;
            end
            if (instr_valid && (instr_count_q != CNT_MAX)) begin
                instr_count_d = instr_count_q + 1'b1;
            end

            // Flags are sticky; a later PASS after a FAIL leaves both set.
            if (status_store) begin
                if (dmem_wdata == STATUS_PASS) begin
                    pass_d = 1'b1;
                end else begin
                    fail_d = 1'b1;
                end
            end

            // Sentinel wins over the watchdog on its final cycle.
            if (sentinel) begin
                state_d   = ST_DONE;
                halt_pc_d = pc;
            end else if (cycle_count_q == WDOG_LAST) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!reset) begin
            state_q       <= ST_RUN;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            halt_pc_q     <= 32'h0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            halt_pc_q     <= halt_pc_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

`ifdef CPU_TEST_MONITOR_MISALIGN_EN
    logic misalign_q, misalign_d;

    // Sticky misaligned-store detector, active only in RUN.
    always_comb begin
        misalign_d = misalign_q;
        if (in_run && mem_write && (dmem_addr[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    // Misalign flag register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign state       = state_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Directed self-checking bench for cpu_test_monitor (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_cpu_test_monitor;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SENT = 32'h0000_006F;
    localparam logic [31:0] PASS_CODE = 32'hC0DE_CAFE;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        mem_write = 1'b0;
    logic [31:0] dmem_addr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;

    logic [1:0]  mon_state;
    logic        mon_pass;
    logic        mon_fail;
    logic [31:0] mon_halt_pc;
    logic [31:0] mon_cycle_count;
    logic [31:0] mon_instr_count;
    logic        mon_misalign_err;

    int checks   = 0;
    int failures = 0;

    cpu_test_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc           (pc),
        .mem_write    (mem_write),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .state        (mon_state),
        .pass         (mon_pass),
        .fail         (mon_fail),
        .halt_pc      (mon_halt_pc),
        .cycle_count  (mon_cycle_count),
        .instr_count  (mon_instr_count),
        .misalign_err (mon_misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Apply one cycle of stimulus, then advance past the next rising edge.
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic we, input logic [31:0] a, input logic [31:0] d);
        instr_valid = v;
        instr       = i;
        pc          = p;
        mem_write   = we;
        dmem_addr   = a;
        dmem_wdata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        idle(n);
        reset = 1'b1;
    endtask

    task automatic check_cleared(input string pfx);
        check({pfx, "_state"},    {30'h0, mon_state}, 32'h0);
        check({pfx, "_pass"},     {31'h0, mon_pass}, 32'h0);
        check({pfx, "_fail"},     {31'h0, mon_fail}, 32'h0);
        check({pfx, "_halt_pc"},  mon_halt_pc, 32'h0);
        check({pfx, "_cycles"},   mon_cycle_count, 32'h0);
        check({pfx, "_instrs"},   mon_instr_count, 32'h0);
        check({pfx, "_misalign"}, {31'h0, mon_misalign_err}, 32'h0);
    endtask

    logic exp_mis;

    initial begin
`ifdef CPU_TEST_MONITOR_MISALIGN_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        // Reset held for 5 clocks.
        do_reset(5);
        check_cleared("rst");

        // PASS then halt: store on retire 1, sentinel at pc 0x20 on retire 7.
        step(1'b1, NOP, 32'h0, 1'b1, 32'h0, PASS_CODE);
        for (int k = 1; k < 6; k++) step(1'b1, NOP, 32'(k * 4), 1'b0, 32'h0, 32'h0);
        check("pass_running", {30'h0, mon_state}, 32'h0);
        check("pass_flag_early", {31'h0, mon_pass}, 32'h1);
        step(1'b1, SENT, 32'h20, 1'b0, 32'h0, 32'h0);
        check("pass_state", {30'h0, mon_state}, 32'h1);
        check("pass_pass", {31'h0, mon_pass}, 32'h1);
        check("pass_fail", {31'h0, mon_fail}, 32'h0);
        check("pass_halt_pc", mon_halt_pc, 32'h20);
        check("pass_instrs", mon_instr_count, 32'd7);
        check("pass_cycles", mon_cycle_count, 32'd7);
        // DONE is terminal: a failing store and more retires are ignored.
        step(1'b1, NOP, 32'h24, 1'b1, 32'h0, 32'h1);
        idle(3);
        check("done_frozen_fail", {31'h0, mon_fail}, 32'h0);
        check("done_frozen_instrs", mon_instr_count, 32'd7);
        check("done_frozen_cycles", mon_cycle_count, 32'd7);

        // FAIL then halt; one idle cycle in between (counts a cycle, not an instr).
        do_reset(2);
        step(1'b1, NOP, 32'h0, 1'b1, 32'h0, 32'h0000_0001);
        idle(1);
        step(1'b1, SENT, 32'h8, 1'b0, 32'h0, 32'h0);
        check("fail_state", {30'h0, mon_state}, 32'h1);
        check("fail_fail", {31'h0, mon_fail}, 32'h1);
        check("fail_pass", {31'h0, mon_pass}, 32'h0);
        check("fail_halt_pc", mon_halt_pc, 32'h8);
        check("fail_instrs", mon_instr_count, 32'd2);
        check("fail_cycles", mon_cycle_count, 32'd3);

        // Timeout: 20 RUN cycles with a retire every cycle, no sentinel.
        do_reset(2);
        for (int k = 0; k < 19; k++) step(1'b1, NOP, 32'(k * 4), 1'b0, 32'h0, 32'h0);
        check("to_run_at_19", {30'h0, mon_state}, 32'h0);
        check("to_cycles_19", mon_cycle_count, 32'd19);
        step(1'b1, NOP, 32'h4C, 1'b0, 32'h0, 32'h0);
        check("to_state", {30'h0, mon_state}, 32'h2);
        check("to_cycles", mon_cycle_count, 32'd20);
        check("to_instrs", mon_instr_count, 32'd20);
        step(1'b1, SENT, 32'h50, 1'b1, 32'h0, PASS_CODE);
        idle(2);
        check("to_frozen_state", {30'h0, mon_state}, 32'h2);
        check("to_frozen_cycles", mon_cycle_count, 32'd20);
        check("to_frozen_pass", {31'h0, mon_pass}, 32'h0);
        check("to_frozen_halt_pc", mon_halt_pc, 32'h0);

        // Tie: sentinel on the 20th cycle gives DONE, then a 1-cycle reset.
        do_reset(2);
        for (int k = 0; k < 19; k++) step(1'b1, NOP, 32'(k * 4), 1'b0, 32'h0, 32'h0);
        step(1'b1, SENT, 32'h4C, 1'b0, 32'h0, 32'h0);
        check("tie_state", {30'h0, mon_state}, 32'h1);
        check("tie_halt_pc", mon_halt_pc, 32'h4C);
        check("tie_cycles", mon_cycle_count, 32'd20);
        do_reset(1);
        check_cleared("tie_rst");

        // Misaligned store to a non-status address, then FAIL followed by PASS.
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h6, 32'h1);
        check("mis_flag", {31'h0, mon_misalign_err}, {31'h0, exp_mis});
        check("mis_no_fail", {31'h0, mon_fail}, 32'h0);
        check("mis_instrs", mon_instr_count, 32'd0);
        step(1'b1, NOP, 32'h4, 1'b1, 32'h0, 32'h5);
        step(1'b1, NOP, 32'h8, 1'b1, 32'h0, PASS_CODE);
        check("both_fail", {31'h0, mon_fail}, 32'h1);
        check("both_pass", {31'h0, mon_pass}, 32'h1);
        check("both_state", {30'h0, mon_state}, 32'h0);
        check("both_instrs", mon_instr_count, 32'd2);
        check("both_cycles", mon_cycle_count, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
